// File: rtl/b11_gen2.sv
// b11_gen2: parametrised character-scrambler FSM.
// It samples a symbol while stbi is high. When stbi drops it runs the
// seed / mix / reduce / offset steps on a signed accumulator, then emits the
// magnitude of the result on x_out together with a one-cycle x_valid pulse.
// Optional build macro: B11_GEN2_SAT_EN. When it is defined, a result whose
// magnitude does not fit in DATA_W bits saturates to all ones.
module b11_gen2 #(
  parameter int DATA_W  = 6,
  parameter int MOD     = 26,
  parameter int CNT_MAX = 25,
  parameter int OFF0    = 21,
  parameter int OFF1    = 42,
  parameter int OFF2    = 7,
  parameter int OFF3    = 28
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_in,
  input  logic              stbi,
  output logic [DATA_W-1:0] x_out,
  output logic              x_valid,
  output logic              busy
);

  localparam int CW = DATA_W + 3;

  localparam logic signed [CW-1:0] C_MOD  = CW'(MOD);
  localparam logic signed [CW-1:0] C_LIM  = CW'((1 << DATA_W) - 1);
  localparam logic signed [CW-1:0] C_OFF0 = CW'(OFF0);
  localparam logic signed [CW-1:0] C_OFF1 = CW'(OFF1);
  localparam logic signed [CW-1:0] C_OFF2 = CW'(OFF2);
  localparam logic signed [CW-1:0] C_OFF3 = CW'(OFF3);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_CHECK, S_SEED, S_MIX,
    S_RED_UP, S_RED_DN, S_OFFSET, S_EMIT
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [DATA_W-1:0]        r_in, w_in_nxt;
  logic [DATA_W-1:0]        r_cont, w_cont_nxt;
  logic signed [CW-1:0]     r_cont1, w_cont1_nxt;
  logic [DATA_W-1:0]        r_x_out, w_x_out_nxt;
  logic                     r_x_valid;

  logic signed [CW-1:0]     w_in_ext;
  logic signed [CW-1:0]     w_cont_ext;
  logic                     w_special;

  // Magnitude of the accumulator reduced to DATA_W bits (truncate or saturate).
  function automatic logic [DATA_W-1:0] out_mag(input logic signed [CW-1:0] acc);
    logic [CW-1:0] mag;
    mag = acc[CW-1] ? CW'(-acc) : CW'(acc);
`ifdef B11_GEN2_SAT_EN
    if (mag > CW'(C_LIM)) return '1;
    return mag[DATA_W-1:0];
`else
    return mag[DATA_W-1:0];
`endif
  endfunction

  assign w_in_ext   = signed'({3'b000, r_in});
  assign w_cont_ext = signed'({3'b000, r_cont});
  assign w_special  = (r_in == '0) || (r_in == '1);

  assign x_out   = r_x_out;
  assign x_valid = r_x_valid;
  assign busy    = (r_state != S_IDLE) && (r_state != S_WAIT);

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_in      <= '0;
      r_cont    <= '0;
      r_cont1   <= '0;
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_in      <= w_in_nxt;
      r_cont    <= w_cont_nxt;
      r_cont1   <= w_cont1_nxt;
      r_x_out   <= w_x_out_nxt;
      r_x_valid <= (r_state == S_EMIT);
    end
  end

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    w_state_nxt = r_state;
    w_in_nxt    = r_in;
    w_cont_nxt  = r_cont;
    w_cont1_nxt = r_cont1;
    w_x_out_nxt = r_x_out;
    case (r_state)
      S_IDLE: begin
        w_cont_nxt  = '0;
        w_in_nxt    = x_in;
        w_x_out_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_in_nxt    = x_in;
        w_state_nxt = stbi ? S_WAIT : S_CHECK;
      end
      S_CHECK: begin
        if (w_special) begin
          w_cont_nxt  = (r_cont < DATA_W'(CNT_MAX)) ? r_cont + 1'b1 : '0;
          w_cont1_nxt = w_in_ext;
          w_state_nxt = S_EMIT;
        end else if (w_in_ext <= C_MOD) begin
          w_state_nxt = S_SEED;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_SEED: begin
        w_cont1_nxt = r_in[0] ? (w_cont_ext <<< 1) : w_cont_ext;
        w_state_nxt = S_MIX;
      end
      S_MIX: begin
        if (r_in[1]) begin
          w_cont1_nxt = w_in_ext + r_cont1;
          w_state_nxt = S_RED_UP;
        end else begin
          w_cont1_nxt = w_in_ext - r_cont1;
          w_state_nxt = S_RED_DN;
        end
      end
      S_RED_UP: begin
        if (r_cont1 > C_MOD) w_cont1_nxt = r_cont1 - C_MOD;
        else                 w_state_nxt = S_OFFSET;
      end
      S_RED_DN: begin
        if (r_cont1 > C_LIM) w_cont1_nxt = r_cont1 + C_MOD;
        else                 w_state_nxt = S_OFFSET;
      end
      S_OFFSET: begin
        case (r_in[3:2])
          2'b00:   w_cont1_nxt = r_cont1 - C_OFF0;
          2'b01:   w_cont1_nxt = r_cont1 - C_OFF1;
          2'b10:   w_cont1_nxt = r_cont1 + C_OFF2;
          default: w_cont1_nxt = r_cont1 + C_OFF3;
        endcase
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        w_x_out_nxt = out_mag(r_cont1);
        w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_b11_gen2.sv
// Testbench for b11_gen2: a table of directed symbols with hand-computed
// results and latencies on the default configuration, plus hand-written
// sequences for the stbi hold and a reset in the middle of a reduce on an
// 8-bit / MOD=100 instance.
module tb_b11_gen2;

  localparam int EXP_SAT =
`ifdef B11_GEN2_SAT_EN
    63;
`else
    23;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] x_in;
  logic       stbi;
  logic [5:0] x_out;
  logic       x_valid;
  logic       busy;

  logic       rst8;
  logic [7:0] x_in8;
  logic       stbi8;
  logic [7:0] x_out8;
  logic       x_valid8;
  logic       busy8;

  int errors = 0;
  int checks = 0;

  b11_gen2 u_dut (
    .clock(clock), .reset(reset), .x_in(x_in), .stbi(stbi),
    .x_out(x_out), .x_valid(x_valid), .busy(busy)
  );

  b11_gen2 #(.DATA_W(8), .MOD(100)) u_dut8 (
    .clock(clock), .reset(rst8), .x_in(x_in8), .stbi(stbi8),
    .x_out(x_out8), .x_valid(x_valid8), .busy(busy8)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    logic [5:0] vin;
    bit         vld;
    logic [5:0] xo;
    int         lat;
  } vec_t;

  vec_t tbl[35];
  int   ntbl = 0;

  task automatic add(input bit r, input logic [5:0] v, input bit vl,
                     input logic [5:0] xo, input int lat);
    tbl[ntbl].rst = r;
    tbl[ntbl].vin = v;
    tbl[ntbl].vld = vl;
    tbl[ntbl].xo  = xo;
    tbl[ntbl].lat = lat;
    ntbl++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Release a symbol from WAIT and count cycles from CHECK entry to x_valid.
  task automatic send(input logic [5:0] v, output bit got, output int lat);
    @(negedge clock);
    x_in = v;
    stbi = 1'b0;
    @(posedge clock); #1;
    stbi = 1'b1;
    check($sformatf("busy_in_check_%0d", v), busy, 1);
    got = 0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clock); #1;
      if (x_valid) begin
        got = 1;
        lat = c;
      end
    end
  endtask

  task automatic send8(input logic [7:0] v, output bit got, output int lat);
    @(negedge clock);
    x_in8 = v;
    stbi8 = 1'b0;
    @(posedge clock); #1;
    stbi8 = 1'b1;
    got = 0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clock); #1;
      if (x_valid8) begin
        got = 1;
        lat = c;
      end
    end
  endtask

  initial begin
    bit got;
    int lat;

    reset = 1'b1; x_in = '0; stbi = 1'b1;
    rst8  = 1'b1; x_in8 = '0; stbi8 = 1'b1;

    // Vector table: {reset first, symbol, x_valid expected, x_out, latency}
    add(0, 6'd5,  1, 6'd37, 6);   // seed 0, mix 5, offset -42 -> -37
    add(0, 6'd63, 1, 6'd63, 2);   // special, cont -> 1
    add(0, 6'd3,  1, 6'd16, 6);   // 2, 5, -16
    add(0, 6'd27, 0, 6'd16, 0);   // above MOD: dropped, x_out held
    add(0, 6'd26, 1, 6'd8,  7);   // 1, 27, reduce once -> 1, +7 -> 8
    add(0, 6'd12, 1, 6'd39, 6);   // 1, 11, +28 -> 39
    add(1, 6'd0,  1, 6'd0,  2);   // reset, then zeros: cont 1..25
    for (int i = 0; i < 24; i++) add(0, 6'd0, 1, 6'd0, 2);
    add(0, 6'd5,  1, 6'(EXP_SAT), 6); // 50, -45, -87
    add(0, 6'd3,  1, 6'd20, 8);   // 53 -> 27 -> 1, -21 -> -20
    add(0, 6'd0,  1, 6'd0,  2);   // cont 25 wraps to 0
    add(0, 6'd5,  1, 6'd37, 6);   // cont 0 again -> same as first

    repeat (3) @(posedge clock);
    #1;
    check("reset_x_out", x_out, 0);
    check("reset_x_valid", x_valid, 0);
    check("reset_busy", busy, 0);
    check("reset8_x_out", x_out8, 0);
    @(negedge clock);
    reset = 1'b0;
    rst8  = 1'b0;
    @(posedge clock);   // IDLE -> WAIT

    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].rst) begin
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        @(posedge clock);
      end
      send(tbl[i].vin, got, lat);
      check($sformatf("v%0d_valid", i), got, tbl[i].vld);
      if (tbl[i].vld) begin
        check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
        @(posedge clock); #1;
        check($sformatf("v%0d_pulse_width", i), x_valid, 0);
      end
      check($sformatf("v%0d_x_out", i), x_out, tbl[i].xo);
    end

    // stbi held high: remains in WAIT, idle, output unchanged
    @(negedge clock);
    x_in = 6'd5;
    stbi = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      check($sformatf("hold_busy_%0d", c), busy, 0);
      check($sformatf("hold_valid_%0d", c), x_valid, 0);
    end
    check("hold_x_out", x_out, 37);

    // 8-bit instance: special symbol, then reset while in RED_UP
    send8(8'd255, got, lat);
    check("w8_special_valid", got, 1);
    check("w8_special_x_out", x_out8, 255);
    @(negedge clock);
    x_in8 = 8'd3;
    stbi8 = 1'b0;
    @(posedge clock); #1;   // CHECK
    stbi8 = 1'b1;
    repeat (3) @(posedge clock);  // SEED, MIX, RED_UP
    #1;
    check("w8_busy_in_reduce", busy8, 1);
    #2;
    rst8 = 1'b1;
    #1;
    check("w8_async_x_out", x_out8, 0);
    check("w8_async_x_valid", x_valid8, 0);
    check("w8_async_busy", busy8, 0);
    @(negedge clock);
    rst8 = 1'b0;
    @(posedge clock);   // IDLE -> WAIT
    send8(8'd5, got, lat);
    check("w8_after_reset_valid", got, 1);
    check("w8_after_reset_latency", lat, 6);
    check("w8_after_reset_x_out", x_out8, 37);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
